// File: rtl/aes_core_arbiter.sv
// Round-robin front-end sharing one combinational AES core between two requesters.
// Core inputs are held for SETTLE_CYCLES before the outputs are captured (multicycle path).
module aes_core_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_plaintext,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_plaintext,
    input  logic [127:0] req1_key,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_cipher_text,
    output logic [127:0] rsp0_keyout,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_cipher_text,
    output logic [127:0] rsp1_keyout,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic [127:0] core_cipher_text,
    input  logic [127:0] core_keyout,
    output logic         busy,
    output logic         owner
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("aes_core_arbiter: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       ptr;
    logic       rsp_vld;
    logic       grant0, grant1;
    logic       accept;
    logic       rsp_hs;

    // A lone request wins outright; a tie goes to the pointer.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !ptr);
        grant1 = req1_valid && (!req0_valid ||  ptr);
    end

    assign req0_ready = (state == IDLE) && !rst && grant0;
    assign req1_ready = (state == IDLE) && !rst && grant1;
    assign accept     = req0_ready || req1_ready;
    assign rsp_hs     = rsp_vld && (owner ? rsp1_ready : rsp0_ready);

    assign rsp0_valid = rsp_vld && !owner;
    assign rsp1_valid = rsp_vld &&  owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_hs)     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= 4'd0;
            ptr              <= 1'b0;
            owner            <= 1'b0;
            rsp_vld          <= 1'b0;
            core_plaintext   <= '0;
            core_key         <= '0;
            rsp0_cipher_text <= '0;
            rsp0_keyout      <= '0;
            rsp1_cipher_text <= '0;
            rsp1_keyout      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    core_plaintext <= grant0 ? req0_plaintext : req1_plaintext;
                    core_key       <= grant0 ? req0_key       : req1_key;
                    owner          <= !grant0;
                    ptr            <= grant0;  // prefer the loser next time
                    cnt            <= CNT_INIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    rsp_vld <= 1'b1;
                    if (owner) begin
                        rsp1_cipher_text <= core_cipher_text;
                        rsp1_keyout      <= core_keyout;
                    end else begin
                        rsp0_cipher_text <= core_cipher_text;
                        rsp0_keyout      <= core_keyout;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_hs) rsp_vld <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench: main instance at SETTLE_CYCLES=2 plus instances at 1 and 15.
// Core model output drifts every cycle so the capture instant is observable.
module tb_aes_core_arbiter;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_KO  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ct_f(logic [127:0] pt, logic [127:0] key, int c);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ key ^ {96'b0, 32'(c)};
    endfunction

    function automatic logic [127:0] ko_f(logic [127:0] pt, logic [127:0] key, int c);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_KO;
        return ~key ^ {96'b0, 32'(c)};
    endfunction

    // main instance
    logic         r0v, r0r, r1v, r1r, s0v, s0r, s1v, s1r, m_busy, m_owner;
    logic [127:0] r0p, r0k, r1p, r1k, s0c, s0k, s1c, s1k, m_cpt, m_ckey, m_cct, m_cko;

    assign m_cct = ct_f(m_cpt, m_ckey, cyc);
    assign m_cko = ko_f(m_cpt, m_ckey, cyc);

    aes_core_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_plaintext(r0p), .req0_key(r0k),
        .req1_valid(r1v), .req1_ready(r1r), .req1_plaintext(r1p), .req1_key(r1k),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_cipher_text(s0c), .rsp0_keyout(s0k),
        .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_cipher_text(s1c), .rsp1_keyout(s1k),
        .core_plaintext(m_cpt), .core_key(m_ckey),
        .core_cipher_text(m_cct), .core_keyout(m_cko),
        .busy(m_busy), .owner(m_owner)
    );

    // SETTLE_CYCLES=1 and 15 instances share one requester-0 stimulus
    logic         xv, xr_a, xr_b, xa_s0v, xb_s0v;
    logic [127:0] xp, xk, xa_c, xa_k, xb_c, xb_k, xa_cpt, xa_ckey, xb_cpt, xb_ckey;
    logic         xa_r1r, xa_s1v, xa_busy, xa_own, xb_r1r, xb_s1v, xb_busy, xb_own;
    logic [127:0] xa_s1c, xa_s1k, xb_s1c, xb_s1k;
    logic [127:0] xa_cct, xa_cko, xb_cct, xb_cko;

    assign xa_cct = ct_f(xa_cpt, xa_ckey, cyc);
    assign xa_cko = ko_f(xa_cpt, xa_ckey, cyc);
    assign xb_cct = ct_f(xb_cpt, xb_ckey, cyc);
    assign xb_cko = ko_f(xb_cpt, xb_ckey, cyc);

    aes_core_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .req0_valid(xv), .req0_ready(xr_a), .req0_plaintext(xp), .req0_key(xk),
        .req1_valid(1'b0), .req1_ready(xa_r1r), .req1_plaintext(128'h0), .req1_key(128'h0),
        .rsp0_valid(xa_s0v), .rsp0_ready(1'b1), .rsp0_cipher_text(xa_c), .rsp0_keyout(xa_k),
        .rsp1_valid(xa_s1v), .rsp1_ready(1'b1), .rsp1_cipher_text(xa_s1c), .rsp1_keyout(xa_s1k),
        .core_plaintext(xa_cpt), .core_key(xa_ckey),
        .core_cipher_text(xa_cct), .core_keyout(xa_cko),
        .busy(xa_busy), .owner(xa_own)
    );

    aes_core_arbiter #(.SETTLE_CYCLES(15)) dut_s15 (
        .clk(clk), .rst(rst),
        .req0_valid(xv), .req0_ready(xr_b), .req0_plaintext(xp), .req0_key(xk),
        .req1_valid(1'b0), .req1_ready(xb_r1r), .req1_plaintext(128'h0), .req1_key(128'h0),
        .rsp0_valid(xb_s0v), .rsp0_ready(1'b1), .rsp0_cipher_text(xb_c), .rsp0_keyout(xb_k),
        .rsp1_valid(xb_s1v), .rsp1_ready(1'b1), .rsp1_cipher_text(xb_s1c), .rsp1_keyout(xb_s1k),
        .core_plaintext(xb_cpt), .core_key(xb_ckey),
        .core_cipher_text(xb_cct), .core_keyout(xb_cko),
        .busy(xb_busy), .owner(xb_own)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Polls the main instance for a grant; returns after the accept edge with
    // c = cycle stamp of that edge.
    task automatic wait_grant(output int idx, output int c);
        idx = -1;
        c   = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (r0r || r1r) begin
                idx = r1r ? 1 : 0;
                step();
                c = cyc;
                return;
            end
            step();
        end
        chk("grant_timeout", 128'(idx), 128'd0);
    endtask

    logic [127:0] p0 = 128'h0badcafe_0badcafe_12345678_9abcdef0;
    logic [127:0] k0 = 128'h11111111_22222222_33333333_44444444;
    logic [127:0] p1 = 128'hfeedface_deadbeef_01020304_05060708;
    logic [127:0] k1 = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

    initial begin
        int idx, c, last, exp_idx;
        logic [127:0] hold_c, hold_k;

        rst = 1'b1;
        r0v = 1'b1; r0p = FIPS_PT; r0k = FIPS_KEY;
        r1v = 1'b1; r1p = p1;      r1k = k1;
        s0r = 1'b1; s1r = 1'b1;
        xv = 1'b0; xp = '0; xk = '0;

        // reset with both valids high
        step(); step();
        chk("rst_req0_ready", 128'(r0r), 128'd0);
        chk("rst_req1_ready", 128'(r1r), 128'd0);
        chk("rst_core_pt", m_cpt, 128'd0);
        chk("rst_core_key", m_ckey, 128'd0);
        chk("rst_rsp_valids", {s0v, s1v}, 128'd0);
        chk("rst_rsp_payloads", s0c | s0k | s1c | s1k, 128'd0);
        chk("rst_busy_owner", {m_busy, m_owner}, 128'd0);
        rst = 1'b0;
        #1;
        chk("rel_req0_ready", 128'(r0r), 128'd1);
        chk("rel_req1_ready", 128'(r1r), 128'd0);

        // FIPS-197 vector on req0
        wait_grant(idx, c);
        chk("fips_grant", 128'(idx), 128'd0);
        chk("fips_core_pt", m_cpt, FIPS_PT);
        chk("fips_busy_owner", {m_busy, m_owner}, 128'b10);
        chk("wait_no_ready", {r0r, r1r}, 128'd0);
        step();
        chk("fips_rsp_early", 128'(s0v), 128'd0);
        step();
        chk("fips_rsp_valid", 128'(s0v), 128'd1);
        chk("fips_cipher", s0c, FIPS_CT);
        chk("fips_keyout", s0k, FIPS_KO);
        chk("fips_rsp1_quiet", 128'(s1v), 128'd0);
        last = c;
        r0p = p0; r0k = k0;

        // both continuously valid: grants continue 1,0,1,0 at 4-cycle spacing
        for (int g = 0; g < 4; g++) begin
            exp_idx = (g % 2 == 0) ? 1 : 0;
            wait_grant(idx, c);
            chk("rr_grant", 128'(idx), 128'(exp_idx));
            chk("rr_spacing", 128'(c - last), 128'd4);
            last = c;
            step(); step();
            if (exp_idx == 1) begin
                chk("rr_rsp_route", {s0v, s1v}, 128'b01);
                chk("rr_cipher1", s1c, ct_f(p1, k1, c + 2));
                chk("rr_keyout1", s1k, ko_f(p1, k1, c + 2));
            end else begin
                chk("rr_rsp_route", {s0v, s1v}, 128'b10);
                chk("rr_cipher0", s0c, ct_f(p0, k0, c + 2));
                chk("rr_keyout0", s0k, ko_f(p0, k0, c + 2));
            end
        end

        // backpressure on requester 1
        s1r = 1'b0;
        wait_grant(idx, c);
        chk("bp_grant", 128'(idx), 128'd1);
        step(); step();
        hold_c = ct_f(p1, k1, c + 2);
        hold_k = ko_f(p1, k1, c + 2);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 128'(s1v), 128'd1);
            chk("bp_cipher", s1c, hold_c);
            chk("bp_keyout", s1k, hold_k);
            chk("bp_no_ready", {r0r, r1r}, 128'd0);
            step();
        end
        s1r = 1'b1;
        step();
        chk("bp_idle", 128'(m_busy), 128'd0);
        chk("bp_next_ready", {r0r, r1r}, 128'b10);

        // reset during WAIT discards the job
        wait_grant(idx, c);
        chk("rw_grant", 128'(idx), 128'd0);
        rst = 1'b1;
        step();
        r0v = 1'b0; r1v = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rw_no_rsp", {s0v, s1v, m_busy}, 128'd0);
        end
        r0v = 1'b1; r1v = 1'b1;
        wait_grant(idx, c);
        chk("rw_ptr_reset", 128'(idx), 128'd0);
        r0v = 1'b0; r1v = 1'b0;

        // SETTLE_CYCLES = 1 and 15 latency and capture instant
        xv = 1'b1; xp = p0; xk = k1;
        #1;
        chk("x_ready", {xr_a, xr_b}, 128'b11);
        step();
        c = cyc;
        xv = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            chk("s1_valid", 128'(xa_s0v), 128'(k == 2));
            chk("s15_valid", 128'(xb_s0v), 128'(k == 16));
            if (k == 2) begin
                chk("s1_cipher", xa_c, ct_f(p0, k1, c + 1));
                chk("s1_keyout", xa_k, ko_f(p0, k1, c + 1));
            end
            if (k == 16) begin
                chk("s15_cipher", xb_c, ct_f(p0, k1, c + 15));
                chk("s15_keyout", xb_k, ko_f(p0, k1, c + 15));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
